// File: rtl/stim_gen_hs_if.sv
// stim_gen_hs_if: operand/handshake bundle between the stimulus generator
// and the DUT input port.
//   D      : NUM_OPERANDS*WIDTH operands, channel c at [c*WIDTH +: WIDTH]
//   VOUT   : operands valid (generator -> DUT)
//   RDY    : DUT ready (DUT -> generator)
//   RESP_V : one pulse per DUT result (DUT -> generator)
// master = generator side, slave = DUT side.
interface stim_gen_hs_if #(
  parameter int WIDTH        = 32,
  parameter int NUM_OPERANDS = 3
);
  logic [NUM_OPERANDS*WIDTH-1:0] D;
  logic                          VOUT;
  logic                          RDY;
  logic                          RESP_V;

  modport master (output D, output VOUT, input  RDY, input  RESP_V);
  modport slave  (input  D, input  VOUT, output RDY, output RESP_V);
endinterface

// File: rtl/stim_gen_hs.sv
// stim_gen_hs: handshake-correct operand stream generator.
// Issues NUM_TX operand words (LFSR or incrementing source) over a
// valid/ready port, throttles at MAX_OUTSTANDING unanswered operations,
// then drains results (or times out) and raises END_SIM.
// Ports:
//   CLK, RST          clock, async active-high reset
//   EN, MODE          start request / source select (sampled in IDLE)
//   bus (master)      D, VOUT out; RDY, RESP_V in
//   TX_CNT, RESP_CNT  accepted transfers / counted responses
//   OUTSTANDING       operations in flight
//   END_SIM, TIMEOUT, ERR  sticky status flags
// Optional feature: define STIM_GEN_FP_SPECIAL_EN to inject FP32 special
// values on channel 0 every 16th transfer (requires WIDTH >= 32).
module stim_gen_hs #(
  parameter int          WIDTH           = 32,
  parameter int          NUM_OPERANDS    = 3,
  parameter int          NUM_TX          = 1024,
  parameter logic [31:0] SEED            = 32'hACE1_0001,
  parameter int          MAX_OUTSTANDING = 8,
  parameter int          DRAIN_TIMEOUT   = 256
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic                                 EN,
  input  logic                                 MODE,
  stim_gen_hs_if.master                        bus,
  output logic [31:0]                          TX_CNT,
  output logic [31:0]                          RESP_CNT,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] OUTSTANDING,
  output logic                                 END_SIM,
  output logic                                 TIMEOUT,
  output logic                                 ERR
);
  localparam int OW = $clog2(MAX_OUTSTANDING+1);
  localparam int TW = $clog2(DRAIN_TIMEOUT+2);
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef logic [NUM_OPERANDS-1:0][31:0] lfsr_vec_t;

  function automatic lfsr_vec_t seed_vec();
    lfsr_vec_t   v;
    logic [31:0] m;
    for (int c = 0; c < NUM_OPERANDS; c++) begin
      m    = SEED ^ (32'(c) * 32'h9E37_79B9);
      v[c] = (m == 32'h0) ? 32'h1 : m;  // all-zero would lock the LFSR
    end
    return v;
  endfunction

  localparam lfsr_vec_t LFSR_SEEDS = seed_vec();

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
  endfunction

  logic [1:0]  state_q, state_d;
  logic        mode_q, mode_d;
  logic [31:0] tx_cnt_q, tx_cnt_d;
  logic [31:0] resp_cnt_q, resp_cnt_d;
  logic [OW-1:0] out_q, out_d;
  logic [TW-1:0] timer_q, timer_d;
  logic        timeout_q, timeout_d;
  logic        err_q, err_d;
  lfsr_vec_t   lfsr_q, lfsr_d;

  logic vout, xfer, resp_ok, resp_bad;

  // VOUT depends on registers only, so it can never fall without a transfer.
  assign vout     = (state_q == S_RUN) && (out_q < OW'(MAX_OUTSTANDING));
  assign xfer     = vout && bus.RDY;
  assign resp_ok  = bus.RESP_V && (out_q != '0) &&
                    ((state_q == S_RUN) || (state_q == S_DRAIN));
  // A response with nothing in flight is an error in every state; a transfer
  // in that same cycle cannot be what it answers, so it still counts up.
  assign resp_bad = bus.RESP_V && (out_q == '0);

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    tx_cnt_d   = tx_cnt_q;
    resp_cnt_d = resp_cnt_q;
    out_d      = out_q;
    timer_d    = timer_q;
    timeout_d  = timeout_q;
    err_d      = err_q | resp_bad;
    lfsr_d     = lfsr_q;

    if (xfer) begin
      tx_cnt_d = tx_cnt_q + 32'd1;
      for (int c = 0; c < NUM_OPERANDS; c++) lfsr_d[c] = lfsr_step(lfsr_q[c]);
    end
    if (resp_ok) resp_cnt_d = resp_cnt_q + 32'd1;

    case ({xfer, resp_ok})
      2'b10:   out_d = out_q + OW'(1);
      2'b01:   out_d = out_q - OW'(1);
      default: out_d = out_q;
    endcase

    case (state_q)
      S_IDLE: if (EN) begin
        state_d = S_RUN;
        mode_d  = MODE;
      end
      S_RUN: if (xfer && (tx_cnt_q == 32'(NUM_TX - 1))) begin
        state_d = S_DRAIN;
        timer_d = '0;
      end
      S_DRAIN: begin
        if (out_q == '0) begin
          state_d = S_DONE;
        end else if (timer_q == TW'(DRAIN_TIMEOUT)) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else if (bus.RESP_V) begin
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = S_DONE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      mode_q     <= 1'b0;
      tx_cnt_q   <= '0;
      resp_cnt_q <= '0;
      out_q      <= '0;
      timer_q    <= '0;
      timeout_q  <= 1'b0;
      err_q      <= 1'b0;
      lfsr_q     <= LFSR_SEEDS;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      tx_cnt_q   <= tx_cnt_d;
      resp_cnt_q <= resp_cnt_d;
      out_q      <= out_d;
      timer_q    <= timer_d;
      timeout_q  <= timeout_d;
      err_q      <= err_d;
      lfsr_q     <= lfsr_d;
    end
  end

  // Operand channels: decoded from registers, so D is stable while stalled.
  logic [NUM_OPERANDS-1:0][WIDTH-1:0] d_ch;

  for (genvar c = 0; c < NUM_OPERANDS; c++) begin : g_ch
    logic [WIDTH-1:0] gen_val;
    assign gen_val = mode_q ? WIDTH'(tx_cnt_q + 32'(c))
                            : WIDTH'({lfsr_q[c], lfsr_q[c]});
`ifdef STIM_GEN_FP_SPECIAL_EN
    if (c == 0) begin : g_fp
      logic [31:0] sp;
      assign sp = (tx_cnt_q[5:4] == 2'd0) ? 32'h0000_0000 :
                  (tx_cnt_q[5:4] == 2'd1) ? 32'h8000_0000 :
                  (tx_cnt_q[5:4] == 2'd2) ? 32'h7F80_0000 : 32'h7FC0_0000;
      assign d_ch[c] = (tx_cnt_q[3:0] == 4'hF) ? WIDTH'(sp) : gen_val;
    end else begin : g_plain
      assign d_ch[c] = gen_val;
    end
`else
    assign d_ch[c] = gen_val;
`endif
  end

  assign bus.D       = d_ch;
  assign bus.VOUT    = vout;
  assign TX_CNT      = tx_cnt_q;
  assign RESP_CNT    = resp_cnt_q;
  assign OUTSTANDING = out_q;
  assign END_SIM     = (state_q == S_DONE);
  assign TIMEOUT     = timeout_q;
  assign ERR         = err_q;
endmodule
